// File: rtl/div_unit_pkg.sv
// Shared types for the iterative divider: FSM state encoding.
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_ST_IDLE = 2'd0,
      DIV_ST_CALC = 2'd1,
      DIV_ST_FIX  = 2'd2,
      DIV_ST_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider (DIV/DIVU/MOD/MODU) for the EX stage.
// Works on magnitudes, then applies truncating-division signs in FIX.
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   div_state_e       state;
   div_state_e       next_state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_r;
   logic [WIDTH-1:0] quo_r;
   logic [WIDTH-1:0] dvsr_r;
   logic             neg_q;
   logic             neg_r;
   logic             zero_r;

   // Operand magnitudes; |100..0| is 100..0 as an unsigned WIDTH-bit value.
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             b_zero;
   assign a_mag  = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag  = (is_signed && b[WIDTH-1]) ? -b : b;
   assign b_zero = (b == '0);

   // One restoring step: shift the next dividend bit in and trial-subtract.
   logic [WIDTH:0] shifted;
   logic [WIDTH:0] trial;
   logic           fits;
   assign shifted = {rem_r, quo_r[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvsr_r};
   assign fits    = (shifted >= {1'b0, dvsr_r});

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      if (rst) state <= DIV_ST_IDLE;
      else     state <= next_state;
   end

   // Next-state logic; flush aborts from any state, even over start.
   always_comb begin
      // NOTE: default first so no path leaves next_state unassigned (no latch).
      next_state = state;
      if (flush) begin
         next_state = DIV_ST_IDLE;
      end else begin
         case (state)
            DIV_ST_IDLE: if (start) next_state = b_zero ? DIV_ST_FIX : DIV_ST_CALC;
            DIV_ST_CALC: if (cnt == CNT_W'(WIDTH - 1)) next_state = DIV_ST_FIX;
            DIV_ST_FIX:  next_state = DIV_ST_DONE;
            DIV_ST_DONE: next_state = DIV_ST_IDLE;
            default:     next_state = DIV_ST_IDLE;
         endcase
      end
   end

   // Handshake outputs decoded from state.
   always_comb begin
      busy = (state != DIV_ST_IDLE);
      done = (state == DIV_ST_DONE);
   end

   // Datapath: capture operands, iterate, then sign-fix into the held result registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: these are a handful of flops, not a memory, so all of them are
      // reset; the result outputs must read zero straight out of reset.
      if (rst) begin
         cnt         <= '0;
         rem_r       <= '0;
         quo_r       <= '0;
         dvsr_r      <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         zero_r      <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (!flush) begin
         case (state)
            DIV_ST_IDLE: begin
               if (start) begin
                  // Divide-by-zero keeps the raw dividend so it can be returned as-is.
                  quo_r  <= b_zero ? a : a_mag;
                  dvsr_r <= b_mag;
                  rem_r  <= '0;
                  cnt    <= '0;
                  neg_q  <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r  <= is_signed & a[WIDTH-1];
                  zero_r <= b_zero;
               end
            end
            DIV_ST_CALC: begin
               rem_r <= fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
               quo_r <= {quo_r[WIDTH-2:0], fits};
               cnt   <= cnt + CNT_W'(1);
            end
            DIV_ST_FIX: begin
               if (zero_r) begin
                  quotient    <= '1;
                  remainder   <= quo_r;
                  div_by_zero <= 1'b1;
               end else begin
                  quotient    <= neg_q ? -quo_r : quo_r;
                  remainder   <= neg_r ? -rem_r : rem_r;
                  div_by_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected results,
// directed cases, control/flush/reset scenarios and random vectors.
module tb_div_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         is_signed;
   logic         flush;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   div_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .flush       (flush),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
   } res_t;

   res_t sb[$];
   int   passed = 0;
   int   total  = 0;

   // Reference: Verilog truncating / and %, plus divide-by-zero and overflow rules.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
      res_t m;
      logic [W-1:0] min_neg;
      min_neg = {1'b1, {(W-1){1'b0}}};
      if (y == '0) begin
         m.q = '1; m.r = x; m.dbz = 1'b1;
      end else if (s && x == min_neg && y == '1) begin
         m.q = min_neg; m.r = '0; m.dbz = 1'b0;
      end else if (s) begin
         m.q = W'($signed(x) / $signed(y));
         m.r = W'($signed(x) % $signed(y));
         m.dbz = 1'b0;
      end else begin
         m.q = x / y; m.r = x % y; m.dbz = 1'b0;
      end
      return m;
   endfunction

   // Drive one start pulse on the next negedge and push its expected result.
   task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input res_t e);
      @(negedge clk);
      a = x; b = y; is_signed = s; start = 1'b1;
      sb.push_back(e);
   endtask

   // Wait (bounded) for done; operands are scrambled after acceptance.
   task automatic wait_done(output int lat, output int busy_lo, output bit seen);
      lat = 0; busy_lo = 0; seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         start = 1'b0;
         a = $urandom; b = $urandom; is_signed = 1'($urandom_range(0, 1));
         lat++;
         if (!busy) busy_lo++;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input res_t e,
                         output res_t got, output res_t exp, output int lat, output int busy_lo,
                         output bit seen);
      issue(x, y, s, e);
      wait_done(lat, busy_lo, seen);
      got = {quotient, remainder, div_by_zero};
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
   endtask

   task automatic test_reset;
      #1;
      total++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0) begin
         $display("FAIL reset_state got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      end else passed++;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unsigned;
      res_t got, exp; int lat, blo; bit seen;
      run_op(32'd100, 32'd7, 1'b0, res_t'{q: 32'd14, r: 32'd2, dbz: 1'b0}, got, exp, lat, blo, seen);
      total++;
      if (!seen || got !== exp) $display("FAIL unsigned_100_7 got %h want %h", got, exp);
      else passed++;
      total++;
      if (lat !== W + 2) $display("FAIL unsigned_latency got %0d want %0d", lat, W + 2);
      else passed++;
      total++;
      if (blo !== 0) $display("FAIL unsigned_busy got %0d low cycles want 0", blo);
      else passed++;
   endtask

   task automatic test_signed;
      res_t got, exp; int lat, blo; bit seen;
      run_op(32'hFFFF_FFF9, 32'd2, 1'b1, res_t'{q: 32'hFFFF_FFFD, r: 32'hFFFF_FFFF, dbz: 1'b0},
             got, exp, lat, blo, seen);
      total++;
      if (!seen || got !== exp) $display("FAIL signed_m7_2 got %h want %h", got, exp);
      else passed++;
      run_op(32'd7, 32'hFFFF_FFFE, 1'b1, res_t'{q: 32'hFFFF_FFFD, r: 32'd1, dbz: 1'b0},
             got, exp, lat, blo, seen);
      total++;
      if (!seen || got !== exp) $display("FAIL signed_7_m2 got %h want %h", got, exp);
      else passed++;
   endtask

   task automatic test_div_by_zero;
      res_t got, exp; int lat, blo; bit seen;
      for (int s = 0; s < 2; s++) begin
         run_op(32'd5, 32'd0, 1'(s), res_t'{q: 32'hFFFF_FFFF, r: 32'd5, dbz: 1'b1},
                got, exp, lat, blo, seen);
         total++;
         if (!seen || got !== exp) $display("FAIL div_zero_s%0d got %h want %h", s, got, exp);
         else passed++;
         total++;
         if (lat !== 2) $display("FAIL div_zero_latency_s%0d got %0d want 2", s, lat);
         else passed++;
      end
   endtask

   task automatic test_overflow;
      res_t got, exp; int lat, blo; bit seen;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, res_t'{q: 32'h8000_0000, r: 32'd0, dbz: 1'b0},
             got, exp, lat, blo, seen);
      total++;
      if (!seen || got !== exp) $display("FAIL overflow_signed got %h want %h", got, exp);
      else passed++;
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, res_t'{q: 32'd0, r: 32'h8000_0000, dbz: 1'b0},
             got, exp, lat, blo, seen);
      total++;
      if (!seen || got !== exp) $display("FAIL overflow_unsigned got %h want %h", got, exp);
      else passed++;
   endtask

   task automatic test_control;
      res_t got, exp;
      int   ndone;
      bit   busy_after;
      int   late_done;
      // Start during CALC must be ignored: one done, original operands.
      issue(32'd100, 32'd7, 1'b0, res_t'{q: 32'd14, r: 32'd2, dbz: 1'b0});
      ndone = 0; got = '0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (i == 9) begin
            start = 1'b1; a = 32'd50; b = 32'd5; is_signed = 1'b0;
         end
         if (done) begin
            if (ndone == 0) got = {quotient, remainder, div_by_zero};
            ndone++;
         end
      end
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      total++;
      if (ndone !== 1) $display("FAIL busy_start_ignored got %0d dones want 1", ndone);
      else passed++;
      total++;
      if (got !== exp) $display("FAIL busy_start_result got %h want %h", got, exp);
      else passed++;

      // Flush mid-CALC: busy drops next cycle, no done, old results held.
      issue(32'd1000, 32'd3, 1'b0, res_t'{q: 32'd333, r: 32'd1, dbz: 1'b0});
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      busy_after = busy;
      late_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      void'(sb.pop_back());
      total++;
      if (busy_after !== 1'b0) $display("FAIL flush_busy got %b want 0", busy_after);
      else passed++;
      total++;
      if (late_done !== 0) $display("FAIL flush_no_done got %0d dones want 0", late_done);
      else passed++;
      total++;
      if (quotient !== 32'd14 || remainder !== 32'd2)
         $display("FAIL flush_held got q=%h r=%h want q=0000000e r=00000002", quotient, remainder);
      else passed++;

      // Flush and start together in IDLE: request dropped.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; a = 32'd9; b = 32'd3; is_signed = 1'b0;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      busy_after = busy;
      late_done = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) late_done++;
      end
      total++;
      if (busy_after !== 1'b0 || late_done !== 0)
         $display("FAIL flush_start_same got busy=%b dones=%0d want busy=0 dones=0", busy_after, late_done);
      else passed++;
   endtask

   task automatic test_async_reset;
      res_t got, exp; int lat, blo; bit seen;
      issue(32'd100, 32'd7, 1'b0, res_t'{q: 32'd14, r: 32'd2, dbz: 1'b0});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, div_by_zero} !== 3'b000 || quotient !== '0 || remainder !== '0)
         $display("FAIL async_reset got busy=%b done=%b dbz=%b q=%h r=%h want all 0",
                  busy, done, div_by_zero, quotient, remainder);
      else passed++;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      run_op(32'd100, 32'd7, 1'b0, res_t'{q: 32'd14, r: 32'd2, dbz: 1'b0}, got, exp, lat, blo, seen);
      total++;
      if (!seen || got !== exp || lat !== W + 2)
         $display("FAIL after_reset got %h lat=%0d want %h lat=%0d", got, lat, exp, W + 2);
      else passed++;
   endtask

   task automatic test_random;
      res_t got, exp; int lat, blo; bit seen;
      logic [W-1:0] x, y; logic s;
      for (int n = 0; n < 1000; n++) begin
         x = $urandom;
         y = ($urandom_range(0, 1) == 1) ? W'($urandom) : W'($urandom_range(1, 300));
         s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 3) == 0) y = -y;
         if (y == '0) y = 32'd1;
         run_op(x, y, s, model(x, y, s), got, exp, lat, blo, seen);
         total++;
         if (!seen || got !== exp || lat !== W + 2)
            $display("FAIL random a=%h b=%h s=%b got %h lat=%0d want %h", x, y, s, got, lat, exp);
         else passed++;
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0; a = '0; b = '0;
      test_reset;
      test_unsigned;
      test_signed;
      test_div_by_zero;
      test_overflow;
      test_control;
      test_async_reset;
      test_random;
      total++;
      if (sb.size() !== 0) $display("FAIL scoreboard_empty got %0d entries want 0", sb.size());
      else passed++;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
